// File: rtl/hamming74_decoder_if.sv
// Valid/ready codeword-in / data-out bus for the Hamming(7,4) decoder.
// The slave modport is the decoder side; master is the link/consumer side.
interface hamming74_decoder_if;
  logic       in_valid;
  logic       in_ready;
  logic [6:0] in_code;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_data;
  logic       out_corrected;
  logic [2:0] out_syndrome;

  modport slave (
    input  in_valid, in_code, out_ready,
    output in_ready, out_valid, out_data, out_corrected, out_syndrome
  );

  modport master (
    output in_valid, in_code, out_ready,
    input  in_ready, out_valid, out_data, out_corrected, out_syndrome
  );
endinterface

// File: rtl/hamming74_decoder.sv
// Hamming(7,4) single-error-correcting decoder: two-stage valid/ready pipeline
// with a saturating count of corrected words delivered to the consumer.
module hamming74_decoder #(
  parameter int unsigned CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  hamming74_decoder_if.slave   bus,
  input  logic                 clr_count,
  output logic [CNT_W-1:0]     corr_count
);

  localparam int unsigned CODE_W = 7;
  localparam int unsigned DATA_W = 4;
  localparam int unsigned SYN_W  = 3;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [CODE_W-1:0] code1;
  logic              v1;
  logic [SYN_W-1:0]  syn1_c;
  logic [CODE_W-1:0] fixed_c;
  logic [DATA_W-1:0] data2;
  logic              corr2;
  logic [SYN_W-1:0]  syn2;
  logic              v2;
  logic              adv1;
  logic              adv2;

  // in_ready depends only on pipeline occupancy and out_ready, never on in_valid
  assign adv2        = !v2 || bus.out_ready;
  assign adv1        = !v1 || adv2;
  assign bus.in_ready = adv1;

  // Syndrome from the registered codeword; bit i of the code is position i+1
  always_comb begin
    syn1_c    = '0;
    syn1_c[0] = code1[0] ^ code1[2] ^ code1[4] ^ code1[6];
    syn1_c[1] = code1[1] ^ code1[2] ^ code1[5] ^ code1[6];
    syn1_c[2] = code1[3] ^ code1[4] ^ code1[5] ^ code1[6];
  end

  // Flip the bit the syndrome points at; syndrome 0 leaves the word untouched
  always_comb begin
    fixed_c = code1;
    for (int i = 0; i < int'(CODE_W); i++) begin
      if (syn1_c == SYN_W'(i + 1)) begin
        fixed_c[i] = ~code1[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1    <= 1'b0;
      code1 <= '0;
    end else if (adv1) begin
      v1 <= bus.in_valid;
      if (bus.in_valid) begin
        code1 <= bus.in_code;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2    <= 1'b0;
      data2 <= '0;
      corr2 <= 1'b0;
      syn2  <= '0;
    end else if (adv2) begin
      v2 <= v1;
      if (v1) begin
        data2 <= {fixed_c[6], fixed_c[5], fixed_c[4], fixed_c[2]};
        corr2 <= (syn1_c != '0);
        syn2  <= syn1_c;
      end
    end
  end

  // Saturating corrected-word count; clear takes priority over increment
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      corr_count <= '0;
    end else if (clr_count) begin
      corr_count <= '0;
    end else if (v2 && bus.out_ready && corr2 && (corr_count != CNT_MAX)) begin
      corr_count <= corr_count + CNT_W'(1);
    end
  end

  assign bus.out_valid     = v2;
  assign bus.out_data      = data2;
  assign bus.out_corrected = corr2;
  assign bus.out_syndrome  = syn2;

endmodule

// File: tb/tb_hamming74_decoder.sv
// Directed bench for hamming74_decoder (CNT_W=2) with an expected-output queue
// checked at every output handshake plus a reference model of corr_count.
module tb_hamming74_decoder;

  logic       clk;
  logic       rst;
  logic       clr_count;
  logic [1:0] corr_count;

  hamming74_decoder_if bus ();

  hamming74_decoder #(.CNT_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .clr_count  (clr_count),
    .corr_count (corr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  logic [7:0] exp_q[$];   // {data, corrected, syndrome}
  int         exp_cnt;
  logic       stall;
  logic [7:0] prev_out;
  logic [8:0] e;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference encoder, independent of the decoder's correction path
  function automatic logic [6:0] enc(input logic [3:0] d);
    logic [6:0] c;
    c    = '0;
    c[2] = d[0];
    c[4] = d[1];
    c[5] = d[2];
    c[6] = d[3];
    c[0] = c[2] ^ c[4] ^ c[6];
    c[1] = c[2] ^ c[5] ^ c[6];
    c[3] = c[4] ^ c[5] ^ c[6];
    return c;
  endfunction

  task automatic send(input logic [6:0] c, input logic [3:0] d, input logic corr, input logic [2:0] s);
    int n;
    n = 0;
    bus.in_valid = 1'b1;
    bus.in_code  = c;
    @(negedge clk);
    while (!bus.in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("in_ready_timeout", 32'(bus.in_ready), 32'(1));
    @(posedge clk);
    exp_q.push_back({d, corr, s});
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_timeout", 32'(exp_q.size()), 32'(0));
    @(posedge clk);
    #1;
  endtask

  // Output scoreboard, hold-under-stall check and corr_count model
  always @(negedge clk) begin
    if (rst) begin
      exp_cnt = 0;
      stall   = 1'b0;
    end else begin
      chk("corr_count", 32'(corr_count), 32'(exp_cnt));
      if (stall) begin
        chk("stall_hold",
            32'({bus.out_valid, bus.out_data, bus.out_corrected, bus.out_syndrome}),
            32'({1'b1, prev_out}));
      end
      e = 9'h0;
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() != 0) e = {1'b1, exp_q.pop_front()};
        chk("out_word",
            32'({1'b1, bus.out_data, bus.out_corrected, bus.out_syndrome}),
            32'(e));
      end
      if (clr_count) exp_cnt = 0;
      else if (e[8] && e[3] && exp_cnt < 3) exp_cnt++;
      stall    = bus.out_valid && !bus.out_ready;
      prev_out = {bus.out_data, bus.out_corrected, bus.out_syndrome};
    end
  end

  initial begin
    rst           = 1'b1;
    clr_count     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_code   = '0;
    bus.out_ready = 1'b0;

    // Reset state
    @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
    chk("rst_out_data", 32'(bus.out_data), 32'(0));
    chk("rst_corr_count", 32'(corr_count), 32'(0));
    @(posedge clk);
    #1 rst = 1'b0;
    bus.out_ready = 1'b1;

    // Clean, data-bit error, parity-bit error
    send(7'h55, 4'hB, 1'b0, 3'd0);
    wait_idle();
    chk("clean_cnt", 32'(corr_count), 32'(0));
    send(7'h45, 4'hB, 1'b1, 3'd5);
    wait_idle();
    chk("data_err_cnt", 32'(corr_count), 32'(1));
    send(7'h5D, 4'hB, 1'b1, 3'd4);
    wait_idle();
    chk("parity_err_cnt", 32'(corr_count), 32'(2));

    // All single-bit flips of all codewords, then all clean codewords, back to back
    for (int d = 0; d < 16; d++) begin
      for (int k = 0; k < 7; k++) begin
        send(enc(4'(d)) ^ (7'(1) << k), 4'(d), 1'b1, 3'(k + 1));
      end
    end
    for (int d = 0; d < 16; d++) begin
      send(enc(4'(d)), 4'(d), 1'b0, 3'd0);
    end
    wait_idle();

    // Counter saturation at 3 after a clear
    clr_count = 1'b1;
    @(posedge clk);
    #1 clr_count = 1'b0;
    chk("clr_idle", 32'(corr_count), 32'(0));
    for (int i = 0; i < 5; i++) begin
      send(7'h45, 4'hB, 1'b1, 3'd5);
      wait_idle();
      chk("cnt_sat", 32'(corr_count), 32'((i < 3) ? i + 1 : 3));
    end

    // Clear coincident with a corrected-word handshake
    bus.out_ready = 1'b0;
    send(7'h45, 4'hB, 1'b1, 3'd5);
    for (int n = 0; n < 10 && !bus.out_valid; n++) @(negedge clk);
    chk("clr_wait_valid", 32'(bus.out_valid), 32'(1));
    @(posedge clk);
    #1 clr_count = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1 clr_count = 1'b0;
    chk("clr_wins", 32'(corr_count), 32'(0));
    chk("clr_drained", 32'(exp_q.size()), 32'(0));

    // Backpressure: two words fill the pipe, third waits
    bus.out_ready = 1'b0;
    send(7'h55, 4'hB, 1'b0, 3'd0);
    send(7'h45, 4'hB, 1'b1, 3'd5);
    bus.in_valid = 1'b1;
    bus.in_code  = 7'h00;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_in_ready", 32'(bus.in_ready), 32'(0));
      chk("bp_out_data", 32'(bus.out_data), 32'(4'hB));
      chk("bp_out_valid", 32'(bus.out_valid), 32'(1));
    end
    @(posedge clk);
    #1 bus.out_ready = 1'b1;
    send(7'h00, 4'h0, 1'b0, 3'd0);
    wait_idle();

    // Asynchronous reset with both stages full
    bus.out_ready = 1'b0;
    send(7'h55, 4'hB, 1'b0, 3'd0);
    send(7'h45, 4'hB, 1'b1, 3'd5);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("ar_out_valid", 32'(bus.out_valid), 32'(0));
    chk("ar_out_data", 32'(bus.out_data), 32'(0));
    chk("ar_out_corrected", 32'(bus.out_corrected), 32'(0));
    chk("ar_out_syndrome", 32'(bus.out_syndrome), 32'(0));
    chk("ar_corr_count", 32'(corr_count), 32'(0));
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    bus.out_ready = 1'b1;
    send(7'h00, 4'h0, 1'b0, 3'd0);
    wait_idle();
    repeat (4) @(negedge clk);
    chk("post_rst_idle", 32'(bus.out_valid), 32'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
